// File: rtl/sd_emmc_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sd_emmc_fifo_pkg
// Shared constants and helpers for the SD/eMMC host single-clock FIFOs.
// The default geometry matches the AXI staging and DMA buffers, so those
// blocks and the FIFO agree on one set of numbers.
// ---------------------------------------------------------------------------
package sd_emmc_fifo_pkg;

  localparam int SD_FIFO_WIDTH = 32;
  localparam int SD_FIFO_DEPTH = 128;

  // The level counter must hold 0..DEPTH inclusive, so it needs one bit
  // more than a pointer into the array.
  function automatic int fifoLevelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sd_emmc_fifo_ram.sv
// ---------------------------------------------------------------------------
// sd_emmc_fifo_ram
// DEPTH x WIDTH storage for sd_emmc_sync_fifo. It has one write port and one
// read port. With FWFT=1 the read is asynchronous, so the head word is always
// presented. With FWFT=0 the read data is registered and loads only on i_re.
// The array itself is never reset. This is the single place to swap in a
// memory macro.
//
// Ports:
//   i_clk    clock
//   i_rst_n  async active-low reset (read register only, FWFT=0)
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_re     read enable (registered read port only)
//   i_raddr  read address
//   o_rdata  read data
// ---------------------------------------------------------------------------
module sd_emmc_fifo_ram
  import sd_emmc_fifo_pkg::*;
#(
  parameter int WIDTH = SD_FIFO_WIDTH,
  parameter int DEPTH = SD_FIFO_DEPTH,
  parameter int FWFT  = 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_async_read
      // Reset and read enable have no role on the asynchronous port.
      logic w_unused_rd;
      assign w_unused_rd = i_rst_n ^ i_re;
      assign o_rdata     = r_mem[i_raddr];
    end else begin : g_reg_read
      // Only the output register is reset, so data_o starts at a known 0.
      // It holds its value whenever no read is accepted.
      logic [WIDTH-1:0] r_rdata;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rdata <= '0;
        end else if (i_re) begin
          r_rdata <= r_mem[i_raddr];
        end
      end
      assign o_rdata = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/sd_emmc_sync_fifo.sv
// ---------------------------------------------------------------------------
// sd_emmc_sync_fifo
// Parametrised single-clock data FIFO for the SD/eMMC host datapath.
// It has runtime watermarks, a fill level, a synchronous flush, sticky
// overflow/underflow flags, and either FWFT or registered-pop output.
//
// Ports:
//   aclk, rst_n            clock, async active-low reset
//   flush_i                synchronous flush (beats push/pop)
//   push_i, data_i, full_o write side
//   pop_i, data_o, empty_o read side
//   level_o                occupancy 0..DEPTH
//   wmark_hi_i/lo_i        almost-full / almost-empty thresholds
//   almost_full_o/empty_o  level_o >= hi / level_o <= lo
//   overflow_o/underflow_o sticky error flags
//   err_clr_i              clears both sticky flags
// ---------------------------------------------------------------------------
module sd_emmc_sync_fifo
  import sd_emmc_fifo_pkg::*;
#(
  parameter  int WIDTH = SD_FIFO_WIDTH,
  parameter  int DEPTH = SD_FIFO_DEPTH,
  parameter  int FWFT  = 1,
  localparam int LVL_W = fifoLevelWidth(DEPTH)
) (
  input  logic             aclk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o,
  input  logic [LVL_W-1:0] wmark_hi_i,
  input  logic [LVL_W-1:0] wmark_lo_i,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             err_clr_i
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_evt;
  logic w_unf_evt;

  // Status comes only from the registered level. Occupancy is counted
  // explicitly, not derived from the pointers.
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);

  // Flush masks both requests, so a flush cycle moves nothing and raises
  // no error flag.
  assign w_push_ok = push_i && !w_full  && !flush_i;
  assign w_pop_ok  = pop_i  && !w_empty && !flush_i;
  assign w_ovf_evt = push_i && w_full   && !flush_i;
  assign w_unf_evt = pop_i  && w_empty  && !flush_i;

  // Pointers wrap on their own. The level moves only when exactly one side
  // is accepted.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky flags ignore flush. A new error event beats err_clr_i in the
  // same cycle, so a flag cannot be lost.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (err_clr_i) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_evt) begin
        r_underflow <= 1'b1;
      end else if (err_clr_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  sd_emmc_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FWFT  (FWFT),
    .AW    (AW)
  ) u_ram (
    .i_clk   (aclk),
    .i_rst_n (rst_n),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_i),
    .i_re    (w_pop_ok),
    .i_raddr (r_rd_ptr),
    .o_rdata (data_o)
  );

  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign level_o        = r_level;
  assign almost_full_o  = (r_level >= wmark_hi_i);
  assign almost_empty_o = (r_level <= wmark_lo_i);
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule
